// File: rtl/rf_pkg.sv
// Shared defaults and the address-width helper for the register-file scoreboard.
package rf_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned NREGS_DEF = 32;
   localparam int unsigned NRD_DEF   = 2;

   function automatic int unsigned rf_addr_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rf_pending.sv
// Pending-write bit per register, popcount tracker and the WAW / orphan hazard flags.
module rf_pending
   import rf_pkg::*;
#(
   parameter int unsigned NREGS = NREGS_DEF,
   parameter int unsigned AW    = rf_addr_width(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_iss_en,
   input  logic [AW-1:0]    i_iss_wa,
   input  logic             i_wb_en,
   input  logic [AW-1:0]    i_wb_wa,
   output logic [NREGS-1:0] o_pend,
   output logic [AW:0]      o_cnt,
   output logic             o_iss_waw,
   output logic             o_wb_orphan
);

   logic [NREGS-1:0] r_pend;
   logic [NREGS-1:0] w_pend_nxt;
   logic [AW:0]      r_cnt;
   logic [AW:0]      w_cnt_nxt;
   logic             w_iss_vld;
   logic             w_wb_vld;
   logic             w_same;
   logic             w_set;
   logic             w_clr;

   always_comb begin
      w_iss_vld = i_iss_en && (i_iss_wa != '0);
      w_wb_vld  = i_wb_en && (i_wb_wa != '0);
      w_same    = w_iss_vld && w_wb_vld && (i_iss_wa == i_wb_wa);
      w_set     = w_iss_vld && !r_pend[i_iss_wa];
      // A writeback racing a fresh issue to the same register leaves it pending.
      w_clr     = w_wb_vld && r_pend[i_wb_wa] && !w_same;

      w_pend_nxt = r_pend;
      if (w_wb_vld) w_pend_nxt[i_wb_wa] = 1'b0;
      if (w_iss_vld) w_pend_nxt[i_iss_wa] = 1'b1;

      w_cnt_nxt = r_cnt + (AW+1)'(w_set) - (AW+1)'(w_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
         r_cnt  <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

   assign o_pend      = r_pend;
   assign o_cnt       = r_cnt;
   assign o_iss_waw   = rst_n && w_iss_vld && r_pend[i_iss_wa] && !w_same;
   assign o_wb_orphan = rst_n && w_wb_vld && !r_pend[i_wb_wa];

endmodule

// File: rtl/rf_scoreboard.sv
// Register file with multi-port combinational reads, optional writeback bypass and
// per-register pending-write scoreboard.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEF,
   parameter int unsigned NREGS  = NREGS_DEF,
   parameter int unsigned NRD    = NRD_DEF,
   parameter int unsigned BYPASS = 1,
   localparam int unsigned AW    = rf_addr_width(NREGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD*AW-1:0]   RF_ADR,
   output logic [NRD*XLEN-1:0] RF_RD,
   output logic [NRD-1:0]      RF_BUSY,
   input  logic                ISS_EN,
   input  logic [AW-1:0]       ISS_WA,
   input  logic                WB_EN,
   input  logic [AW-1:0]       WB_WA,
   input  logic [XLEN-1:0]     WB_WD,
   output logic                ISS_WAW,
   output logic                WB_ORPHAN,
   output logic [AW:0]         PEND_CNT
);

   logic [XLEN-1:0]  r_regs [NREGS];
   logic [NREGS-1:0] w_pend;
   logic             w_wb_vld;

   assign w_wb_vld = WB_EN && (WB_WA != '0);

   // Entry 0 is cleared by reset and never written, so it always reads zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(NREGS); k++) r_regs[k] <= '0;
      end else if (w_wb_vld) begin
         r_regs[WB_WA] <= WB_WD;
      end
   end

   for (genvar g = 0; g < int'(NRD); g++) begin : g_rd
      logic [AW-1:0] w_adr;
      logic          w_hit;
      assign w_adr = RF_ADR[g*AW +: AW];
      assign w_hit = (BYPASS != 0) && w_wb_vld && (WB_WA == w_adr);
      assign RF_RD[g*XLEN +: XLEN] = w_hit ? WB_WD : r_regs[w_adr];
      assign RF_BUSY[g] = w_pend[w_adr] && !w_hit;
   end

   rf_pending #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_pending (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_iss_en    (ISS_EN),
      .i_iss_wa    (ISS_WA),
      .i_wb_en     (WB_EN),
      .i_wb_wa     (WB_WA),
      .o_pend      (w_pend),
      .o_cnt       (PEND_CNT),
      .o_iss_waw   (ISS_WAW),
      .o_wb_orphan (WB_ORPHAN)
   );

endmodule

// File: tb/tb_rf_scoreboard.sv
// Randomized and directed bench for rf_scoreboard against an array-based reference model.
module tb_rf_scoreboard;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NRD*AW-1:0]   rf_adr;
   logic [NRD*XLEN-1:0] rf_rd;
   logic [NRD-1:0]      rf_busy;
   logic                iss_en;
   logic [AW-1:0]       iss_wa;
   logic                wb_en;
   logic [AW-1:0]       wb_wa;
   logic [XLEN-1:0]     wb_wd;
   logic                iss_waw;
   logic                wb_orphan;
   logic [AW:0]         pend_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   logic [XLEN-1:0] m_reg  [NREGS];
   bit              m_pend [NREGS];

   always #5 clk = ~clk;

   rf_scoreboard #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .NRD    (NRD),
      .BYPASS (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .RF_ADR    (rf_adr),
      .RF_RD     (rf_rd),
      .RF_BUSY   (rf_busy),
      .ISS_EN    (iss_en),
      .ISS_WA    (iss_wa),
      .WB_EN     (wb_en),
      .WB_WA     (wb_wa),
      .WB_WD     (wb_wd),
      .ISS_WAW   (iss_waw),
      .WB_ORPHAN (wb_orphan),
      .PEND_CNT  (pend_cnt)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_count();
      int c = 0;
      for (int k = 0; k < NREGS; k++) c += int'(m_pend[k]);
      return c;
   endfunction

   function automatic void m_reset();
      for (int k = 0; k < NREGS; k++) begin
         m_reg[k]  = '0;
         m_pend[k] = 1'b0;
      end
   endfunction

   // Applies inputs shortly after an edge and lets them settle.
   task automatic set_in(input logic ie, input logic [AW-1:0] iw, input logic we,
                         input logic [AW-1:0] ww, input logic [XLEN-1:0] wd,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      iss_en = ie;
      iss_wa = iw;
      wb_en  = we;
      wb_wa  = ww;
      wb_wd  = wd;
      rf_adr = {a1, a0};
      #3;
   endtask

   task automatic check_comb();
      logic [AW-1:0]   a;
      logic [XLEN-1:0] e_rd;
      logic            e_busy;
      logic            hit;
      for (int i = 0; i < NRD; i++) begin
         a      = rf_adr[i*AW +: AW];
         hit    = wb_en && (wb_wa != 0) && (wb_wa == a);
         e_rd   = hit ? wb_wd : ((a == 0) ? '0 : m_reg[a]);
         e_busy = (a != 0) && m_pend[a] && !(wb_en && wb_wa == a);
         check_eq($sformatf("rd%0d", i), 64'(rf_rd[i*XLEN +: XLEN]), 64'(e_rd));
         check_eq($sformatf("busy%0d", i), 64'(rf_busy[i]), 64'(e_busy));
      end
      check_eq("iss_waw", 64'(iss_waw),
               64'(iss_en && iss_wa != 0 && m_pend[iss_wa] && !(wb_en && wb_wa == iss_wa)));
      check_eq("wb_orphan", 64'(wb_orphan), 64'(wb_en && wb_wa != 0 && !m_pend[wb_wa]));
   endtask

   task automatic step();
      check_comb();
      @(posedge clk);
      if (wb_en && wb_wa != 0) begin
         m_reg[wb_wa]  = wb_wd;
         m_pend[wb_wa] = 1'b0;
      end
      if (iss_en && iss_wa != 0) m_pend[iss_wa] = 1'b1;
      #1;
      check_eq("pend_cnt", 64'(pend_cnt), 64'(m_count()));
   endtask

   function automatic logic [AW-1:0] rnd_adr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS - 1));
      return AW'($urandom_range(0, 7));
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n  = 1'b0;
      iss_en = 1'b0;
      iss_wa = '0;
      wb_en  = 1'b0;
      wb_wa  = '0;
      wb_wd  = '0;
      rf_adr = '0;
      m_reset();
      #12;
      check_eq("reset_cnt", 64'(pend_cnt), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Every address on both ports reads zero and idle after reset.
      for (int a = 0; a < NREGS; a++) begin
         set_in(1'b0, '0, 1'b0, '0, '0, AW'(a), AW'(NREGS - 1 - a));
         check_eq("post_reset_rd", 64'(rf_rd), 64'd0);
         step();
      end

      // Issue x5, then bypassed writeback clears it.
      set_in(1'b1, AW'(5), 1'b0, '0, '0, '0, '0);
      step();
      set_in(1'b0, '0, 1'b0, '0, '0, AW'(5), AW'(5));
      check_eq("x5_busy", 64'(rf_busy), 64'd3);
      check_eq("x5_cnt", 64'(pend_cnt), 64'd1);
      step();
      set_in(1'b0, '0, 1'b1, AW'(5), 32'hDEAD_BEEF, AW'(5), '0);
      check_eq("x5_bypass_rd", 64'(rf_rd[XLEN-1:0]), 64'hDEAD_BEEF);
      check_eq("x5_bypass_busy", 64'(rf_busy[0]), 64'd0);
      step();
      check_eq("x5_cnt_after_wb", 64'(pend_cnt), 64'd0);

      // x0 ignores writes and issues.
      set_in(1'b1, '0, 1'b1, '0, 32'h1234_5678, '0, '0);
      check_eq("x0_rd", 64'(rf_rd[XLEN-1:0]), 64'd0);
      check_eq("x0_orphan", 64'(wb_orphan), 64'd0);
      step();
      check_eq("x0_cnt", 64'(pend_cnt), 64'd0);

      // Simultaneous issue + writeback on an already pending x7.
      set_in(1'b1, AW'(7), 1'b0, '0, '0, '0, '0);
      step();
      set_in(1'b1, AW'(7), 1'b1, AW'(7), 32'hA5, AW'(7), AW'(7));
      check_eq("x7_same_waw", 64'(iss_waw), 64'd0);
      step();
      set_in(1'b0, '0, 1'b0, '0, '0, AW'(7), AW'(7));
      check_eq("x7_rd", 64'(rf_rd[XLEN-1:0]), 64'hA5);
      check_eq("x7_busy", 64'(rf_busy), 64'd3);
      check_eq("x7_cnt", 64'(pend_cnt), 64'd1);
      step();
      set_in(1'b0, '0, 1'b1, AW'(7), 32'hA5, '0, '0);
      step();

      // WAW on x3, orphan writeback to x9.
      set_in(1'b1, AW'(3), 1'b0, '0, '0, '0, '0);
      check_eq("x3_first_waw", 64'(iss_waw), 64'd0);
      step();
      set_in(1'b1, AW'(3), 1'b0, '0, '0, '0, '0);
      check_eq("x3_second_waw", 64'(iss_waw), 64'd1);
      step();
      check_eq("x3_cnt", 64'(pend_cnt), 64'd1);
      set_in(1'b0, '0, 1'b1, AW'(9), 32'h9999, '0, '0);
      check_eq("x9_orphan", 64'(wb_orphan), 64'd1);
      step();
      set_in(1'b0, '0, 1'b0, '0, '0, AW'(9), AW'(9));
      check_eq("x9_rd", 64'(rf_rd[XLEN-1:0]), 64'h9999);
      step();

      // Fill all pending bits, then asynchronous reset between edges.
      for (int k = 1; k < NREGS; k++) begin
         set_in(1'b1, AW'(k), 1'b0, '0, '0, '0, '0);
         step();
      end
      check_eq("full_cnt", 64'(pend_cnt), 64'd31);
      set_in(1'b0, '0, 1'b1, AW'(4), 32'h5555, AW'(1), AW'(4));
      rst_n = 1'b0;
      #1;
      m_reset();
      check_eq("arst_cnt", 64'(pend_cnt), 64'd0);
      check_eq("arst_rd_x1", 64'(rf_rd[XLEN-1:0]), 64'd0);
      check_eq("arst_rd_bypass", 64'(rf_rd[2*XLEN-1:XLEN]), 64'h5555);
      check_eq("arst_busy", 64'(rf_busy), 64'd0);
      check_eq("arst_orphan", 64'(wb_orphan), 64'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      set_in(1'b1, AW'(2), 1'b1, AW'(4), 32'h5555, AW'(4), AW'(2));
      step();

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         set_in(1'($urandom_range(0, 1)), rnd_adr(), 1'($urandom_range(0, 1)), rnd_adr(),
                $urandom(), rnd_adr(), rnd_adr());
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_scoreboard.md
RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, register data width in bits.
REQ-002 Parameter NREGS, default 32, register count; SHALL be a power of two, at least 2; AW = log2(NREGS).
REQ-003 Parameter NRD, default 2, number of independent read ports, 1 to 4.
REQ-004 Parameter BYPASS, default 1: 1 forwards same-cycle writeback data to reads; 0 disables forwarding.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 RF_ADR  input  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW].
REQ-008 RF_RD  output  NRD*XLEN  packed read data; port i uses bits [i*XLEN +: XLEN].
REQ-009 RF_BUSY  output  NRD  per-port flag: the addressed register has a pending write.
REQ-010 ISS_EN  input  1  issue strobe; marks the ISS_WA register pending.
REQ-011 ISS_WA  input  AW  issue destination address.
REQ-012 WB_EN  input  1  writeback strobe.
REQ-013 WB_WA  input  AW  writeback address.
REQ-014 WB_WD  input  XLEN  writeback data.
REQ-015 ISS_WAW  output  1  combinational flag: issue targets a register that is already pending and is not being cleared this cycle.
REQ-016 WB_ORPHAN  output  1  combinational flag: writeback targets a nonzero register that is not pending.
REQ-017 PEND_CNT  output  AW+1  registered count of pending registers.

Function
REQ-018 Register 0 SHALL always read zero; writes and issues to it SHALL be ignored, and its pending bit SHALL stay 0.
REQ-019 Reads SHALL be combinational with zero-cycle latency: RF_RD[i] = reg[RF_ADR[i]].
REQ-020 When WB_EN=1 and WB_WA!=0, reg[WB_WA] SHALL take WB_WD at the next rising edge.
REQ-021 Bypass (BYPASS=1): when WB_EN=1, WB_WA!=0 and WB_WA==RF_ADR[i], RF_RD[i] SHALL equal WB_WD in the same cycle.
REQ-022 Pending bit p[k] SHALL be set at the edge on which ISS_EN=1 and ISS_WA==k (k!=0).
REQ-023 Pending bit p[k] SHALL be cleared at the edge on which WB_EN=1 and WB_WA==k, unless an issue to k occurs in the same cycle.
REQ-024 Simultaneous issue and writeback to the same register: the data SHALL be written and p[k] SHALL remain 1 (the new issue wins).
REQ-025 RF_BUSY[i] = p[RF_ADR[i]] AND NOT (BYPASS AND WB_EN AND WB_WA==RF_ADR[i]); it SHALL be 0 for address 0.
REQ-026 Issue to an already-pending register SHALL leave p set, SHALL NOT change PEND_CNT, and SHALL assert ISS_WAW.
REQ-027 Writeback to a non-pending register SHALL still write the data, SHALL leave PEND_CNT unchanged, and SHALL assert WB_ORPHAN.
REQ-028 PEND_CNT SHALL equal the popcount of p at all times and SHALL update in the same edge as p: +1, -1, or 0 net change; it never wraps (maximum NREGS-1).

Reset
REQ-029 rst_n low SHALL immediately, independent of clk, clear all registers to 0, all pending bits to 0, and PEND_CNT to 0.
REQ-030 While rst_n is low, RF_BUSY, ISS_WAW and WB_ORPHAN SHALL be 0, and RF_RD SHALL be 0 for every address except bypassed writeback data.
REQ-031 A reset asserted mid-sequence SHALL discard all in-flight pending state; the first edge after rst_n deasserts SHALL process the inputs normally.

Structure
REQ-032 Package rf_pkg SHALL hold the default XLEN, NREGS and NRD constants and the address-width helper function.
REQ-033 Pending-bit and counter logic SHALL live in one sub-module, rf_pending; the data array and read/bypass muxes SHALL stay in rf_scoreboard.

Verification
REQ-034 Reset, then read every address on all ports -> all reads 0, RF_BUSY=0, PEND_CNT=0.
REQ-035 Issue x5; next cycle read x5 -> RF_BUSY=1 and PEND_CNT=1. Writeback x5=0xDEADBEEF with RF_ADR[0]=5 in the same cycle -> RF_RD[0]=0xDEADBEEF and RF_BUSY[0]=0 that cycle; next cycle PEND_CNT=0.
REQ-036 Writeback x0=0x12345678 and issue x0 -> x0 reads 0, PEND_CNT stays 0, WB_ORPHAN=0.
REQ-037 Issue x7 and writeback x7=0xA5 in the same cycle, with x7 already pending -> x7 reads 0xA5, RF_BUSY stays 1, PEND_CNT unchanged.
REQ-038 Issue x3 twice -> ISS_WAW=1 on the second issue and PEND_CNT=1. Writeback x9 while it is not pending -> WB_ORPHAN=1 and the data is written.
REQ-039 Issue x1 through x31 -> PEND_CNT=31. Assert rst_n low between clock edges -> PEND_CNT=0 and x1 reads 0 before the next edge.
